// File: rtl/maria_bus_pkg.sv
// Shared types and sizing helpers for the MARIA bus arbiter.
package maria_bus_pkg;

  // Bus ownership sequence for one DMA burst.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HALT_WAIT,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_t;

  // Default timing: one CPU tick for halt setup and for bus turnaround,
  // and a generous watchdog on the grant phase.
  localparam int unsigned HALT_SETUP_TICKS_DEF = 1;
  localparam int unsigned RELEASE_TICKS_DEF    = 1;
  localparam int unsigned DMA_WDOG_CYCLES_DEF  = 1024;

  // Width needed to hold values 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/maria_wsync_ctrl.sv
// WSYNC hold: deassert_ready drops CPU RDY until the next scanline start.
module maria_wsync_ctrl (
  input  logic sysclock,
  input  logic reset_b,
  input  logic deassert_ready,
  input  logic line_start,
  output logic ready,
  output logic wsync_active
);

  // Set on WSYNC write; clear on the first line_start after the set cycle.
  // While idle a simultaneous line_start is ignored (set wins); while active a
  // repeated deassert_ready is ignored (line_start clears).
  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      wsync_active <= 1'b0;
    end else if (wsync_active) begin
      // NOTE: flops always use non-blocking assignment so every register
      // samples pre-edge values regardless of block ordering.
      wsync_active <= ~line_start;
    end else begin
      wsync_active <= deassert_ready;
    end
  end

  // RDY is a pure decode of the hold flop, so it has no input-to-output path.
  assign ready = ~wsync_active;

endmodule

// File: rtl/maria_bus_arbiter.sv
// Shared system bus arbiter between the 6502 and MARIA line DMA.
module maria_bus_arbiter
  import maria_bus_pkg::*;
#(
  parameter int unsigned HALT_SETUP_TICKS = HALT_SETUP_TICKS_DEF,
  parameter int unsigned RELEASE_TICKS    = RELEASE_TICKS_DEF,
  parameter int unsigned DMA_WDOG_CYCLES  = DMA_WDOG_CYCLES_DEF
) (
  input  logic sysclock,
  input  logic reset_b,
  input  logic pclk_en,
  input  logic dma_en,
  input  logic zp_written,
  input  logic dma_req,
  input  logic dma_done,
  input  logic deassert_ready,
  input  logic line_start,
  output logic ready,
  output logic halt_b,
  output logic drive_AB,
  output logic dma_grant,
  output logic wsync_active,
  output logic dma_timeout
);

  localparam int unsigned TICK_MAX = (HALT_SETUP_TICKS > RELEASE_TICKS) ?
                                     HALT_SETUP_TICKS : RELEASE_TICKS;
  localparam int unsigned TICK_W   = cnt_width(TICK_MAX);
  localparam int unsigned WDOG_W   = cnt_width(DMA_WDOG_CYCLES - 1);

  localparam logic [TICK_W-1:0] HALT_T    = TICK_W'(HALT_SETUP_TICKS);
  localparam logic [TICK_W-1:0] REL_T     = TICK_W'(RELEASE_TICKS);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(DMA_WDOG_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              pend_q, pend_d;
  logic              tmo_q, tmo_d;
  logic              accept;

  // A request only counts once DMA is enabled and the display list is set up.
  assign accept = dma_req & dma_en & zp_written;

  // State, counters, pending flag and timeout pulse register.
  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ARB_IDLE;
      tick_q  <= '0;
      wdog_q  <= '0;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      wdog_q  <= wdog_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic. Counters only advance while below their target, so
  // they saturate instead of wrapping.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    tick_d  = tick_q;
    wdog_d  = wdog_q;
    pend_d  = pend_q;
    tmo_d   = 1'b0;

    // One-deep queue for a request that arrives while a burst is in flight.
    if (state_q != ARB_IDLE && accept) pend_d = 1'b1;

    unique case (state_q)
      ARB_IDLE: begin
        if (accept || pend_q) begin
          state_d = ARB_HALT_WAIT;
          tick_d  = '0;
          pend_d  = 1'b0;
        end
      end
      ARB_HALT_WAIT: begin
        if (tick_q >= HALT_T) begin
          state_d = ARB_GRANT;
          wdog_d  = '0;
        end else if (pclk_en) begin
          tick_d = tick_q + 1'b1;
        end
      end
      ARB_GRANT: begin
        // A normal finish wins over a watchdog expiry in the same cycle.
        if (dma_done) begin
          state_d = ARB_RELEASE;
          tick_d  = '0;
        end else if (wdog_q >= WDOG_LAST) begin
          state_d = ARB_RELEASE;
          tick_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        if (tick_q >= REL_T) begin
          state_d = ARB_IDLE;
        end else if (pclk_en) begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Bus outputs decode the state register only; drive_AB is a subset of the
  // halted states, so drive_AB=1 always implies halt_b=0.
  assign halt_b      = (state_q == ARB_IDLE);
  assign drive_AB    = (state_q == ARB_GRANT);
  assign dma_grant   = (state_q == ARB_GRANT);
  assign dma_timeout = tmo_q;

  maria_wsync_ctrl u_wsync (
    .sysclock       (sysclock),
    .reset_b        (reset_b),
    .deassert_ready (deassert_ready),
    .line_start     (line_start),
    .ready          (ready),
    .wsync_active   (wsync_active)
  );

endmodule

// File: doc/maria_bus_arbiter.md
Name: maria_bus_arbiter

Overview:
- Owns the shared system bus between the 6502 and MARIA line DMA.
- Sequences halt_b and drive_AB around each DMA burst, and implements the WSYNC ready hold triggered by the register file's deassert_ready pulse.
- Sits beside the MARIA register block:
  - consumes its deassert_ready, zp_written and ctrl DMA-mode bits;
  - produces the halt_b / drive_AB that the register block and CPU core consume.

Parameters:
- HALT_SETUP_TICKS, 1: pclk_en ticks between halt_b falling and bus grant (CPU cycle completion).
- RELEASE_TICKS, 1: pclk_en ticks halt_b stays low after drive_AB drops (bus turnaround).
- DMA_WDOG_CYCLES, 1024: sysclock cycles of grant before forced release.

Ports:
- sysclock  in  1  system clock; all logic on its rising edge.
- reset_b  in  1  asynchronous active-low reset.
- pclk_en  in  1  one-sysclock pulse marking each CPU phase tick.
- dma_en  in  1  ctrl DMA mode field == 2'b10 (DMA on), decoded by parent.
- zp_written  in  1  both display-list pointer bytes written since reset.
- dma_req  in  1  one-cycle pulse from line DMA engine requesting the bus.
- dma_done  in  1  one-cycle pulse: DMA engine finished burst.
- deassert_ready  in  1  one-cycle pulse: WSYNC written.
- line_start  in  1  one-cycle pulse at start of each scanline.
- ready  out  1  CPU RDY.
- halt_b  out  1  CPU halt, active low.
- drive_AB  out  1  MARIA drives address bus.
- dma_grant  out  1  bus granted to DMA engine.
- wsync_active  out  1  WSYNC hold in progress.
- dma_timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset values:
  - ready=1, halt_b=1, drive_AB=0, dma_grant=0, wsync_active=0, dma_timeout=0.
  - State ARB_IDLE; counters 0; pending flag 0.
- Reset mid-operation: everything returns to reset values immediately (async). No burst is resumed.

WSYNC:
- deassert_ready sets wsync_active; ready=0 the next sysclock.
- The next line_start strictly after the setting cycle clears wsync_active; ready=1 the following sysclock.
- deassert_ready and line_start in the same cycle: set wins; the hold lasts until the next line_start.
- Repeated deassert_ready while active: no effect.
- WSYNC is independent of the DMA FSM; both may be active together.

DMA request acceptance:
- dma_req is accepted only when dma_en=1 and zp_written=1; otherwise it is dropped silently.
- An accepted dma_req outside ARB_IDLE sets a one-deep pending flag. Further requests while pending are dropped.

DMA FSM:
- ARB_IDLE:
  - halt_b=1, drive_AB=0.
  - On accepted dma_req or pending=1: clear pending, go to ARB_HALT_WAIT, tick counter=0.
- ARB_HALT_WAIT:
  - halt_b=0.
  - Counter increments on pclk_en.
  - When the counter reaches HALT_SETUP_TICKS, go to ARB_GRANT the next sysclock.
- ARB_GRANT:
  - halt_b=0, drive_AB=1, dma_grant=1. Watchdog counts sysclocks from 0.
  - dma_done → ARB_RELEASE.
  - Watchdog reaching DMA_WDOG_CYCLES-1 → ARB_RELEASE, with dma_timeout pulsed one cycle.
  - dma_done and watchdog in the same cycle: exit normally, no timeout pulse.
- ARB_RELEASE:
  - drive_AB=0, dma_grant=0, halt_b=0.
  - Counter counts pclk_en ticks up to RELEASE_TICKS, then → ARB_IDLE.
- dma_en dropping during HALT_WAIT/GRANT does not abort the burst; it only gates new requests.
- dma_done outside ARB_GRANT is ignored.
- Outputs are registered (decoded from the state register): no combinational input→output paths.
- Counters saturate; they never wrap.
- Invariant: drive_AB=1 implies halt_b=0 at every cycle.

Decomposition:
- Package maria_bus_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_HALT_WAIT, ARB_GRANT, ARB_RELEASE};
  - localparam counter widths derived via $clog2 from the parameters.
- One sub-module, maria_wsync_ctrl: the WSYNC set/clear flop and ready output.
- The FSM and counters stay in the top module.

Test Plan:
- Reset release, no stimulus for 100 cycles → ready=1, halt_b=1, drive_AB=0, all pulses 0.
- dma_en=1, zp_written=1, dma_req at cycle 10, pclk_en every 4 cycles → halt_b=0 at cycle 11, drive_AB=1 after 1 pclk_en tick; dma_done at +40 → drive_AB=0 next cycle, halt_b=1 after 1 further tick.
- zp_written=0 with dma_req → no state change; with dma_en=0 → no state change.
- deassert_ready at cycle 20 and line_start at cycle 20 and cycle 500 → ready=0 from cycle 21 to cycle 500, ready=1 at cycle 501.
- DMA_WDOG_CYCLES=16, grant with no dma_done → dma_timeout pulse on grant cycle 16, then release sequence; halt_b=0 held throughout drive_AB=1.
- Second dma_req during ARB_GRANT → after return to ARB_IDLE, immediate new ARB_HALT_WAIT. A third request during that burst while pending → dropped. Async reset asserted during ARB_GRANT → all outputs at reset values in the same cycle.
